// File: rtl/cmd_pkg.sv
// Shared types and widths for the command receiver slice.
package cmd_pkg;
  localparam int unsigned CMD_W  = 16;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic {IDLE, WAIT_LB} rx_state_t;
  typedef enum logic {TX_IDLE, TX_BUSY} tx_state_t;
endpackage

// File: rtl/cmd_receiver_uart.sv
// Bit-level 8N1 UART transceiver: rx_rdy is sticky until clr_rx_rdy, tx_done pulses once per byte.
module UART
  import cmd_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 2604
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RX,
  output logic              TX,
  output logic              rx_rdy,
  input  logic              clr_rx_rdy,
  output logic [BYTE_W-1:0] rx_data,
  input  logic              trmt,
  input  logic [BYTE_W-1:0] tx_data,
  output logic              tx_done
);
  localparam int unsigned BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BAUD_HALF = BW'(BAUD_DIV / 2 - 1);

  logic              tx_busy_q, tx_busy_d;
  logic [9:0]        tx_shift_q, tx_shift_d;
  logic [BW-1:0]     tx_baud_q, tx_baud_d;
  logic [3:0]        tx_bit_q, tx_bit_d;
  logic              tx_done_q, tx_done_d;

  logic [1:0]        rx_sync_q;
  logic              rx_s;
  logic              rx_busy_q, rx_busy_d;
  logic [BW-1:0]     rx_baud_q, rx_baud_d;
  logic [3:0]        rx_bit_q, rx_bit_d;
  logic [8:0]        rx_shift_q, rx_shift_d;
  logic              rx_rdy_q, rx_rdy_d;
  logic [BYTE_W-1:0] rx_data_q, rx_data_d;

  assign rx_s    = rx_sync_q[1];
  assign TX      = tx_shift_q[0];
  assign tx_done = tx_done_q;
  assign rx_rdy  = rx_rdy_q;
  assign rx_data = rx_data_q;

  // Shifting ones in behind the frame leaves the line idle-high once the stop bit is out.
  always_comb begin
    tx_busy_d  = tx_busy_q;
    tx_shift_d = tx_shift_q;
    tx_baud_d  = tx_baud_q;
    tx_bit_d   = tx_bit_q;
    tx_done_d  = 1'b0;
    if (!tx_busy_q) begin
      if (trmt) begin
        tx_busy_d  = 1'b1;
        tx_shift_d = {1'b1, tx_data, 1'b0};
        tx_baud_d  = '0;
        tx_bit_d   = '0;
      end
    end else if (tx_baud_q == BAUD_LAST) begin
      tx_baud_d  = '0;
      tx_shift_d = {1'b1, tx_shift_q[9:1]};
      if (tx_bit_q == 4'd9) begin
        tx_busy_d = 1'b0;
        tx_done_d = 1'b1;
      end else begin
        tx_bit_d = tx_bit_q + 4'd1;
      end
    end else begin
      tx_baud_d = tx_baud_q + 1'b1;
    end
  end

  // Samples at mid-bit: half a period after the start edge, then every full period.
  always_comb begin
    rx_busy_d  = rx_busy_q;
    rx_baud_d  = rx_baud_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    rx_rdy_d   = clr_rx_rdy ? 1'b0 : rx_rdy_q;
    if (!rx_busy_q) begin
      if (!rx_s) begin
        rx_busy_d = 1'b1;
        rx_baud_d = BAUD_HALF;
        rx_bit_d  = '0;
      end
    end else if (rx_baud_q == '0) begin
      rx_baud_d = BAUD_LAST;
      rx_bit_d  = rx_bit_q + 4'd1;
      if (rx_bit_q == 4'd0 && rx_s) begin
        rx_busy_d = 1'b0;
      end else if (rx_bit_q == 4'd9) begin
        rx_busy_d = 1'b0;
        rx_data_d = rx_shift_q[8:1];
        rx_rdy_d  = 1'b1;
      end else begin
        rx_shift_d = {rx_s, rx_shift_q[8:1]};
      end
    end else begin
      rx_baud_d = rx_baud_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy_q  <= 1'b0;
      tx_shift_q <= '1;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_done_q  <= 1'b0;
      rx_sync_q  <= '1;
      rx_busy_q  <= 1'b0;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_rdy_q   <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      tx_busy_q  <= tx_busy_d;
      tx_shift_q <= tx_shift_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_done_q  <= tx_done_d;
      rx_sync_q  <= {rx_sync_q[0], RX};
      rx_busy_q  <= rx_busy_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_rdy_q   <= rx_rdy_d;
      rx_data_q  <= rx_data_d;
    end
  end
endmodule

// File: rtl/cmd_receiver.sv
// Assembles 16-bit commands (high byte first) from the UART and returns one response byte.
// Optional low-byte timeout is built when CMD_RX_TIMEOUT_EN is defined.
module cmd_receiver
  import cmd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CLKS = 1000000,
  parameter int unsigned BAUD_DIV     = 2604
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RX,
  output logic              TX,
  output logic [CMD_W-1:0]  cmd,
  output logic              cmd_rdy,
  input  logic              clr_cmd_rdy,
  input  logic [BYTE_W-1:0] resp,
  input  logic              send_resp,
  output logic              resp_sent,
  output logic              frame_err
);
  logic              rx_rdy, clr_rx_rdy, tx_done;
  logic [BYTE_W-1:0] rx_data;

  rx_state_t         rx_state_q, rx_state_d;
  logic [BYTE_W-1:0] hb_q, hb_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic              cmd_rdy_q, cmd_rdy_d;

  tx_state_t         tx_state_q, tx_state_d;
  logic              trmt_q, trmt_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              resp_sent_q, resp_sent_d;

`ifdef CMD_RX_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CLKS);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CLKS - 1);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          frame_err_q, frame_err_d;
  assign frame_err = frame_err_q;
`else
  assign frame_err = 1'b0;
`endif

  assign cmd       = cmd_q;
  assign cmd_rdy   = cmd_rdy_q;
  assign resp_sent = resp_sent_q;

  UART #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk        (clk),
    .rst_n      (rst_n),
    .RX         (RX),
    .TX         (TX),
    .rx_rdy     (rx_rdy),
    .clr_rx_rdy (clr_rx_rdy),
    .rx_data    (rx_data),
    .trmt       (trmt_q),
    .tx_data    (tx_data_q),
    .tx_done    (tx_done)
  );

  // clr_rx_rdy stays combinational so the same byte is never seen twice by the FSM.
  always_comb begin
    rx_state_d = rx_state_q;
    hb_d       = hb_q;
    cmd_d      = cmd_q;
    cmd_rdy_d  = clr_cmd_rdy ? 1'b0 : cmd_rdy_q;
    clr_rx_rdy = 1'b0;
`ifdef CMD_RX_TIMEOUT_EN
    to_cnt_d    = to_cnt_q;
    frame_err_d = 1'b0;
`endif
    unique case (rx_state_q)
      IDLE: begin
        if (rx_rdy) begin
          hb_d       = rx_data;
          clr_rx_rdy = 1'b1;
          cmd_rdy_d  = 1'b0;
          rx_state_d = WAIT_LB;
`ifdef CMD_RX_TIMEOUT_EN
          to_cnt_d   = '0;
`endif
        end
      end
      WAIT_LB: begin
        if (rx_rdy) begin
          cmd_d      = {hb_q, rx_data};
          cmd_rdy_d  = 1'b1;
          clr_rx_rdy = 1'b1;
          rx_state_d = IDLE;
        end
`ifdef CMD_RX_TIMEOUT_EN
        else if (to_cnt_q == TO_LAST) begin
          hb_d        = '0;
          frame_err_d = 1'b1;
          rx_state_d  = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      default: rx_state_d = IDLE;
    endcase
  end

  always_comb begin
    tx_state_d  = tx_state_q;
    trmt_d      = 1'b0;
    tx_data_d   = tx_data_q;
    resp_sent_d = resp_sent_q;
    unique case (tx_state_q)
      TX_IDLE: begin
        if (send_resp) begin
          tx_data_d   = resp;
          trmt_d      = 1'b1;
          resp_sent_d = 1'b0;
          tx_state_d  = TX_BUSY;
        end
      end
      TX_BUSY: begin
        if (tx_done) begin
          resp_sent_d = 1'b1;
          tx_state_d  = TX_IDLE;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q  <= IDLE;
      hb_q        <= '0;
      cmd_q       <= '0;
      cmd_rdy_q   <= 1'b0;
      tx_state_q  <= TX_IDLE;
      trmt_q      <= 1'b0;
      tx_data_q   <= '0;
      resp_sent_q <= 1'b0;
`ifdef CMD_RX_TIMEOUT_EN
      to_cnt_q    <= '0;
      frame_err_q <= 1'b0;
`endif
    end else begin
      rx_state_q  <= rx_state_d;
      hb_q        <= hb_d;
      cmd_q       <= cmd_d;
      cmd_rdy_q   <= cmd_rdy_d;
      tx_state_q  <= tx_state_d;
      trmt_q      <= trmt_d;
      tx_data_q   <= tx_data_d;
      resp_sent_q <= resp_sent_d;
`ifdef CMD_RX_TIMEOUT_EN
      to_cnt_q    <= to_cnt_d;
      frame_err_q <= frame_err_d;
`endif
    end
  end
endmodule

// File: tb/tb_cmd_receiver.sv
// Bench for cmd_receiver: serial host driver/monitor plus a byte-level command model.
module tb_cmd_receiver;
  localparam int unsigned BD = 16;
  localparam int unsigned TO = 50000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic        clr_cmd_rdy = 1'b0;
  logic        send_resp = 1'b0;
  logic [7:0]  resp = '0;
  logic        TX, cmd_rdy, resp_sent, frame_err;
  logic [15:0] cmd;

  int errors = 0;
  int checks = 0;
  int fe_count = 0;
  logic [7:0] host_q[$];
  logic [7:0] exp_resp_q[$];

  logic        m_pending = 1'b0;
  logic [7:0]  m_hb = '0;
  logic [15:0] m_cmd = '0;
  logic        m_rdy = 1'b0;

  typedef struct {
    logic [7:0]  hb;
    logic [7:0]  lb;
    logic        clr;
    logic [15:0] exp_cmd;
    logic        exp_rdy;
  } vec_t;
  vec_t tbl[5];

  cmd_receiver #(.TIMEOUT_CLKS(TO), .BAUD_DIV(BD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RX          (RX),
    .TX          (TX),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .resp        (resp),
    .send_resp   (send_resp),
    .resp_sent   (resp_sent),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (frame_err) fe_count++;

  // Host-side serial receiver for the response line.
  initial begin
    forever begin
      logic [7:0] b;
      @(negedge TX);
      repeat (BD / 2) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (BD) @(posedge clk);
        b[i] = TX;
      end
      repeat (BD) @(posedge clk);
      host_q.push_back(b);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RX = f[i];
      cyc(BD);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (!m_pending) begin
      m_pending = 1'b1;
      m_hb = b;
      m_rdy = 1'b0;
    end else begin
      m_cmd = {m_hb, b};
      m_rdy = 1'b1;
      m_pending = 1'b0;
    end
  endtask

  task automatic host_byte(input logic [7:0] b);
    send_byte(b);
    cyc(4);
    model_byte(b);
  endtask

  task automatic check_state(input string name);
    check({name, "_cmd"}, {16'h0, cmd}, {16'h0, m_cmd});
    check({name, "_rdy"}, {31'h0, cmd_rdy}, {31'h0, m_rdy});
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    cyc(1);
    clr_cmd_rdy = 1'b0;
    m_rdy = 1'b0;
  endtask

  task automatic reset_outputs(input string name);
    check({name, "_cmd"}, {16'h0, cmd}, 32'h0);
    check({name, "_rdy"}, {31'h0, cmd_rdy}, 32'h0);
    check({name, "_rsent"}, {31'h0, resp_sent}, 32'h0);
    check({name, "_ferr"}, {31'h0, frame_err}, 32'h0);
    check({name, "_tx"}, {31'h0, TX}, 32'h1);
  endtask

  initial begin
    int n;
    logic [15:0] c;
    logic [7:0]  r;
    int exp_fe;

    tbl[0] = '{8'hA5, 8'h3C, 1'b0, 16'hA53C, 1'b1};
    tbl[1] = '{8'h12, 8'h34, 1'b1, 16'h1234, 1'b0};
    tbl[2] = '{8'h00, 8'h00, 1'b0, 16'h0000, 1'b1};
    tbl[3] = '{8'hFF, 8'hFF, 1'b1, 16'hFFFF, 1'b0};
    tbl[4] = '{8'h80, 8'h01, 1'b0, 16'h8001, 1'b1};

    cyc(3);
    reset_outputs("reset");
    rst_n = 1'b1;
    cyc(3);

    for (int i = 0; i < 5; i++) begin
      host_byte(tbl[i].hb);
      host_byte(tbl[i].lb);
      if (tbl[i].clr) pulse_clr();
      check("tbl_cmd", {16'h0, cmd}, {16'h0, tbl[i].exp_cmd});
      check("tbl_rdy", {31'h0, cmd_rdy}, {31'h0, tbl[i].exp_rdy});
      if (i == 0) begin
        cyc(20);
        check("hold_rdy", {31'h0, cmd_rdy}, 32'h1);
        pulse_clr();
        check("clr_rdy", {31'h0, cmd_rdy}, 32'h0);
      end
    end

    // Back-to-back commands without acknowledge.
    host_byte(8'h12); host_byte(8'h34); check_state("b2b_first");
    host_byte(8'hBE); check_state("b2b_hb");
    check("b2b_hold", {16'h0, cmd}, 32'h1234);
    host_byte(8'hEF); check_state("b2b_second");
    pulse_clr();

    // Latency of cmd_rdy and set-beats-clear in the same cycle.
    host_byte(8'h5C);
    fork
      send_byte(8'h7E);
      begin
        n = 0;
        while (!dut.u_uart.rx_rdy && n < 12 * BD) begin
          cyc(1);
          n++;
        end
        if (n >= 12 * BD) begin
          check("lat_wait", 32'h0, 32'h1);
        end else begin
          check("lat_pre_rdy", {31'h0, cmd_rdy}, 32'h0);
          clr_cmd_rdy = 1'b1;
          cyc(1);
          clr_cmd_rdy = 1'b0;
          check("set_wins_rdy", {31'h0, cmd_rdy}, 32'h1);
          check("lat_cmd", {16'h0, cmd}, 32'h5C7E);
        end
      end
    join
    cyc(4);
    model_byte(8'h7E);
    check_state("lat_after");

    // Response path; a second request while busy must not produce another byte.
    resp = 8'h5A;
    send_resp = 1'b1;
    cyc(1);
    send_resp = 1'b0;
    resp = 8'hC3;
    cyc(2);
    check("rsent_busy", {31'h0, resp_sent}, 32'h0);
    send_resp = 1'b1;
    cyc(1);
    send_resp = 1'b0;
    n = 0;
    while (!resp_sent && n < 15 * BD) begin
      cyc(1);
      n++;
    end
    check("rsent_done", {31'h0, resp_sent}, 32'h1);
    cyc(12 * BD);
    check("resp_count", host_q.size(), 32'd1);
    if (host_q.size() > 0) check("resp_byte", {24'h0, host_q.pop_front()}, 32'h5A);
    host_q.delete();

    // Randomized full-duplex traffic against the model.
    for (int i = 0; i < 12; i++) begin
      c = 16'($urandom);
      r = 8'($urandom);
      resp = r;
      send_resp = 1'b1;
      cyc(1);
      send_resp = 1'b0;
      exp_resp_q.push_back(r);
      host_byte(c[15:8]);
      check_state("rand_hb");
      host_byte(c[7:0]);
      check_state("rand_lb");
      if ($urandom_range(0, 1) == 1) begin
        pulse_clr();
        check_state("rand_clr");
      end
    end
    cyc(12 * BD);
    check("rand_resp_count", host_q.size(), exp_resp_q.size());
    while (host_q.size() > 0 && exp_resp_q.size() > 0)
      check("rand_resp", {24'h0, host_q.pop_front()}, {24'h0, exp_resp_q.pop_front()});
    check("rsent_rand", {31'h0, resp_sent}, 32'h1);

    // Reset between high and low byte.
    host_byte(8'hFF);
    check_state("mid_hb");
    rst_n = 1'b0;
    cyc(2);
    reset_outputs("mid_reset");
    rst_n = 1'b1;
    m_pending = 1'b0;
    m_cmd = '0;
    m_rdy = 1'b0;
    cyc(2);
    host_byte(8'hAB);
    host_byte(8'h01);
    check_state("post_reset");
    check("post_reset_val", {16'h0, cmd}, 32'hAB01);

`ifdef CMD_RX_TIMEOUT_EN
    exp_fe = 1;
    host_byte(8'h77);
    cyc(60000);
    check("to_pulses", fe_count, 32'd1);
    m_pending = 1'b0;
    check_state("to_after");
    host_byte(8'h01);
    host_byte(8'h02);
    check("to_recover", {16'h0, cmd}, 32'h0102);
`else
    exp_fe = 0;
    host_byte(8'h77);
    cyc(40 * BD);
    check_state("wait_hb");
    host_byte(8'h88);
    check("wait_complete", {16'h0, cmd}, 32'h7788);
`endif
    check("ferr_total", fe_count, exp_fe);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
